// File: rtl/parity_pkg.sv
// Shared types and helpers for the framed parity checker: FSM state encoding,
// parity mode constants and a clog2 that never returns less than one bit.
package parity_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/framed_parity_checker_if.sv
// Word/bit-level bus of the framed parity checker. The err_count signal is
// present only when PARITY_ERR_CNT_EN is defined.
interface framed_parity_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              x;
  logic              x_valid;
  logic              frame_clr;
  logic              parity;
  logic [DATA_W-1:0] data_out;
  logic              frame_valid;
  logic              parity_err;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0]  err_count;

  modport master (
    output x, x_valid, frame_clr,
    input  parity, data_out, frame_valid, parity_err, err_count
  );

  modport slave (
    input  x, x_valid, frame_clr,
    output parity, data_out, frame_valid, parity_err, err_count
  );
`else
  localparam int unused_cnt_w = CNT_W;

  modport master (
    output x, x_valid, frame_clr,
    input  parity, data_out, frame_valid, parity_err
  );

  modport slave (
    input  x, x_valid, frame_clr,
    output parity, data_out, frame_valid, parity_err
  );
`endif

endinterface

// File: rtl/parity_shift_acc.sv
// Data shift register (LSB-first arrival, filled from the MSB) and running
// parity accumulator with enable and synchronous clear.
module parity_shift_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              x,
  output logic              acc,
  output logic [DATA_W-1:0] shift
);

  logic [DATA_W-1:0] shift_nxt;

  generate
    if (DATA_W == 1) begin : g_single
      assign shift_nxt = x;
    end else begin : g_multi
      assign shift_nxt = {x, shift[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc   <= 1'b0;
      shift <= '0;
    end else if (en) begin
      acc   <= acc ^ x;
      shift <= shift_nxt;
    end
  end

endmodule

// File: rtl/framed_parity_checker.sv
// Framed serial parity checker: DATA_W data bits then one parity bit, LSB first.
// Optional saturating error counter is built when PARITY_ERR_CNT_EN is defined.
//
// state  | meaning
// S_DATA | accepting data bits, bit_cnt counts accepted bits
// S_PAR  | waiting for the parity bit of the current frame
module framed_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ODD_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  framed_parity_checker_if.slave    bus
);

  localparam int             BCW      = clog2_min1(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
  localparam logic           MODE_BIT = (ODD_MODE == PAR_ODD);

  state_t            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              sa_en, sa_clr, par_done;
  logic              acc;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] data_q;
  logic              fv_q, perr_q;

  parity_shift_acc #(.DATA_W(DATA_W)) u_shift_acc (
    .clk   (clk),
    .reset (reset),
    .en    (sa_en),
    .clr   (sa_clr),
    .x     (bus.x),
    .acc   (acc),
    .shift (shift)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_DATA;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sa_en     = 1'b0;
    sa_clr    = 1'b0;
    par_done  = 1'b0;
    if (bus.frame_clr) begin
      state_d   = S_DATA;
      bit_cnt_d = '0;
      sa_clr    = 1'b1;
    end else if (bus.x_valid) begin
      case (state_q)
        S_DATA: begin
          sa_en = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = S_PAR;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        S_PAR: begin
          par_done = 1'b1;
          sa_clr   = 1'b1;
          state_d  = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  // Result registers sample the completed word before the accumulator clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      fv_q   <= 1'b0;
      perr_q <= 1'b0;
      data_q <= '0;
    end else begin
      fv_q <= par_done;
      if (par_done) begin
        perr_q <= bus.x ^ acc ^ MODE_BIT;
        data_q <= shift;
      end
    end
  end

  assign bus.parity      = acc ^ (bus.x & bus.x_valid & (state_q == S_DATA));
  assign bus.data_out    = data_q;
  assign bus.frame_valid = fv_q;
  assign bus.parity_err  = perr_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (fv_q && perr_q && (err_q != '1)) begin
      err_q <= err_q + CNT_W'(1);
    end
  end

  assign bus.err_count = err_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
